// File: rtl/demux16_reg_bank.sv
// Burst-write register bank: a command sets start pointer and length, data beats land in 16 registers.
// Writes are visible one edge after acceptance; beats stall while din_valid is low, and commands wait while busy.
module demux16_reg_bank #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [AW-1:0]          cmd_len,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [WIDTH-1:0]       din,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          beats_left,
  output logic [DEPTH-1:0]       wr_mask,
  output logic [DEPTH*WIDTH-1:0] q_flat
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    beats_q, beats_d;
  logic [DEPTH-1:0] mask_q, mask_d;
  logic             done_q, done_d;
  logic             wr_en;
  logic [WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      beats_q <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  // Abort takes priority over a beat offered in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ptr_d   = cmd_addr;
          beats_d = cmd_len;
          mask_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (abort) begin
          state_d = IDLE;
        end else if (din_valid) begin
          wr_en         = 1'b1;
          mask_d[ptr_q] = 1'b1;
          ptr_d         = ptr_q + AW'(1);
          if (beats_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beats_d = beats_q - AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[ptr_q] <= din;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign din_ready  = (state_q == BURST);
  assign busy       = (state_q == BURST);
  assign done       = done_q;
  assign beats_left = beats_q;
  assign wr_mask    = mask_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign q_flat[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule
